// File: rtl/bp_pkg.sv
// Branch-predictor shared types: counter-table index width and the update
// record exchanged between the update queue and the 2-bit counter table.
package bp_pkg;

  localparam int unsigned BP_IDX_W = 5;

  // One counter-table update: reset_ctr=1 reseeds to take?01:00, else saturating step.
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                take;
    logic                reset_ctr;
  } bp_upd_t;

endpackage

// File: rtl/bp_update_queue.sv
// Update queue for the branch predictor counter table.
// Buffers up to two resolved branches per cycle from retire and replays them,
// in retire order, one per cycle, as counter-table updates.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   in_valid[1:0]       resolved branch per lane (lane0 older)
//   in_pc               two packed PCs, lane k at [k*PC_W +: PC_W]
//   in_taken, in_new    direction and first-resolution (reseed) per lane
//   in_ready            at least two free entries (registered)
//   upd_stall           table cannot take an update this cycle
//   upd_enable          head entry presented to the table (combinational)
//   upd_idx/take/reset_ctr  head entry fields, zero when empty (combinational)
//   free_cnt            free entries (registered)
module bp_update_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               in_valid,
  input  logic [2*PC_W-1:0]        in_pc,
  input  logic [1:0]               in_taken,
  input  logic [1:0]               in_new,
  output logic                     in_ready,
  input  logic                     upd_stall,
  output logic                     upd_enable,
  output logic [IDX_W-1:0]         upd_idx,
  output logic                     upd_take,
  output logic                     upd_reset_ctr,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bp_upd_t          mem [DEPTH];
  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W:0]   tail_p1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pushes;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] free_next;
  logic             empty;
  logic             do_push;
  bp_upd_t          lane0_e;
  bp_upd_t          lane1_e;
  bp_upd_t          wr0_e;
  bp_upd_t          head_e;

  // Occupancy, compaction mux and head presentation.
  always_comb begin
    count      = CNT_W'(tail - head);
    empty      = (count == '0);
    tail_p1    = tail + (PTR_W+1)'(1);
    do_push    = in_ready && (in_valid != 2'b00);
    pushes     = do_push ? (CNT_W'(in_valid[0]) + CNT_W'(in_valid[1])) : '0;

    lane0_e.idx       = BP_IDX_W'(in_pc[2 +: IDX_W]);
    lane0_e.take      = in_taken[0];
    lane0_e.reset_ctr = in_new[0];
    lane1_e.idx       = BP_IDX_W'(in_pc[PC_W+2 +: IDX_W]);
    lane1_e.take      = in_taken[1];
    lane1_e.reset_ctr = in_new[1];
    // A lone lane1 is written at tail so the queue stays hole-free.
    wr0_e      = in_valid[0] ? lane0_e : lane1_e;

    head_e        = mem[head[PTR_W-1:0]];
    upd_enable    = !empty && !upd_stall && !reset;
    upd_idx       = empty ? '0 : IDX_W'(head_e.idx);
    upd_take      = !empty && head_e.take;
    upd_reset_ctr = !empty && head_e.reset_ctr;

    count_next = count + pushes - CNT_W'(upd_enable);
    free_next  = CNT_W'(DEPTH) - count_next;
  end

  // Pointers and registered flow-control view.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      free_cnt <= CNT_W'(DEPTH);
      in_ready <= 1'b1;
    end else begin
      tail     <= tail + (PTR_W+1)'(pushes);
      if (upd_enable) head <= head + (PTR_W+1)'(1);
      free_cnt <= free_next;
      in_ready <= (free_next >= CNT_W'(2));
    end
  end

  // Entry storage; contents are don't-care until covered by the pointers.
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[tail[PTR_W-1:0]] <= wr0_e;
      if (in_valid == 2'b11) mem[tail_p1[PTR_W-1:0]] <= lane1_e;
    end
  end

  // Producer must not offer branches while the queue is not ready.
  always @(posedge clock) begin
    if (!reset) assert (in_ready || in_valid == 2'b00);
  end

endmodule
